// File: rtl/piso_out_writer.sv
// Parallel-in serial-out result writer: takes a LANES-wide ReLU result and
// emits it one lane per shift as memory writes to an auto-incrementing address.
module piso_out_writer #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int AW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clr,
  input  logic                load,
  input  logic [LANES*DW-1:0] par_in,
  input  logic                shift,
  input  logic                addr_init,
  input  logic [AW-1:0]       base_addr,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic                out_done,
  output logic                busy,
  output logic                overrun
);

  localparam int CW = $clog2(LANES + 1);

  logic [LANES*DW-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;
  logic                out_done_q, out_done_d;
  logic                overrun_q, overrun_d;
  logic [AW-1:0]       addr_base;

  // addr_init takes effect in the same cycle, so a coincident shift writes to base_addr
  assign addr_base = addr_init ? base_addr : addr_q;

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_done_d = 1'b0;
    overrun_d  = overrun_q;
    if (enable) begin
      addr_d = addr_base;
      if (clr) begin
        sr_d      = '0;
        cnt_d     = '0;
        overrun_d = 1'b0;
      end else if (load && (cnt_q == '0)) begin
        sr_d  = par_in;
        cnt_d = CW'(LANES);
      end else begin
        if (load) begin
          overrun_d = 1'b1;
        end
        if (shift && (cnt_q != '0)) begin
          wr_en_d    = 1'b1;
          wr_data_d  = sr_q[DW-1:0];
          wr_addr_d  = addr_base;
          sr_d       = sr_q >> DW;
          cnt_d      = cnt_q - CW'(1);
          addr_d     = addr_base + AW'(1);
          out_done_d = (cnt_q == CW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_done_q <= out_done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign out_done = out_done_q;
  assign busy     = (cnt_q != '0);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_piso_out_writer.sv
// Directed bench for piso_out_writer: hand-computed write sequences, overrun,
// address wrap, stall behaviour and mid-transfer reset.
module tb_piso_out_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clr;
  logic        load;
  logic [31:0] par_in;
  logic        shift;
  logic        addr_init;
  logic [15:0] base_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        out_done;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  piso_out_writer #(.LANES(4), .DW(8), .AW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clr       (clr),
    .load      (load),
    .par_in    (par_in),
    .shift     (shift),
    .addr_init (addr_init),
    .base_addr (base_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_done  (out_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    load      = 1'b0;
    shift     = 1'b0;
    clr       = 1'b0;
    addr_init = 1'b0;
  endtask

  task automatic exp_wr(input string tag, input logic [15:0] a, input logic [7:0] d,
                        input logic done);
    chk({tag, " wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(a));
    chk({tag, " wr_data"}, 32'(wr_data), 32'(d));
    chk({tag, " out_done"}, 32'(out_done), 32'(done));
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, " out_done"}, 32'(out_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clr = 1'b0; load = 1'b0; par_in = '0;
    shift = 1'b0; addr_init = 1'b0; base_addr = '0;
    tick(); tick();
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst out_done", 32'(out_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);

    // basic four-lane transfer at 0x0100
    reset = 1'b0; enable = 1'b1;
    addr_init = 1'b1; base_addr = 16'h0100; tick();
    load = 1'b1; par_in = 32'h44332211; tick();
    chk("ld busy", 32'(busy), 32'd1);
    exp_idle("ld");
    shift = 1'b1; tick(); exp_wr("b0", 16'h0100, 8'h11, 1'b0);
    shift = 1'b1; tick(); exp_wr("b1", 16'h0101, 8'h22, 1'b0);
    shift = 1'b1; tick(); exp_wr("b2", 16'h0102, 8'h33, 1'b0);
    chk("b2 busy", 32'(busy), 32'd1);
    shift = 1'b1; tick(); exp_wr("b3", 16'h0103, 8'h44, 1'b1);
    chk("b3 busy", 32'(busy), 32'd0);
    tick(); exp_idle("b idle");

    // overrun with two lanes left, then clr
    load = 1'b1; par_in = 32'hDDCCBBAA; tick();
    shift = 1'b1; tick(); exp_wr("o0", 16'h0104, 8'hAA, 1'b0);
    shift = 1'b1; tick(); exp_wr("o1", 16'h0105, 8'hBB, 1'b0);
    load = 1'b1; par_in = 32'h99887766; tick();
    chk("ovr flag", 32'(overrun), 32'd1);
    chk("ovr busy", 32'(busy), 32'd1);
    exp_idle("ovr");
    shift = 1'b1; tick(); exp_wr("o2", 16'h0106, 8'hCC, 1'b0);
    chk("ovr sticky", 32'(overrun), 32'd1);
    clr = 1'b1; shift = 1'b1; tick();
    chk("clr overrun", 32'(overrun), 32'd0);
    chk("clr busy", 32'(busy), 32'd0);
    exp_idle("clr");
    load = 1'b1; par_in = 32'h00000055; tick();
    shift = 1'b1; tick(); exp_wr("clr addr", 16'h0107, 8'h55, 1'b0);
    clr = 1'b1; tick();
    chk("clr2 busy", 32'(busy), 32'd0);

    // address wrap
    addr_init = 1'b1; base_addr = 16'hFFFE; tick();
    load = 1'b1; par_in = 32'h04030201; tick();
    shift = 1'b1; tick(); exp_wr("w0", 16'hFFFE, 8'h01, 1'b0);
    shift = 1'b1; tick(); exp_wr("w1", 16'hFFFF, 8'h02, 1'b0);
    shift = 1'b1; tick(); exp_wr("w2", 16'h0000, 8'h03, 1'b0);
    shift = 1'b1; tick(); exp_wr("w3", 16'h0001, 8'h04, 1'b1);
    chk("w overrun", 32'(overrun), 32'd0);

    // stalls between shifts
    load = 1'b1; par_in = 32'h0D0C0B0A; tick();
    shift = 1'b1; tick(); exp_wr("s0", 16'h0002, 8'h0A, 1'b0);
    enable = 1'b0; shift = 1'b1; tick(); exp_idle("stall1");
    enable = 1'b0; shift = 1'b1; tick(); exp_idle("stall2");
    chk("stall wr_addr hold", 32'(wr_addr), 32'h0002);
    chk("stall busy", 32'(busy), 32'd1);
    enable = 1'b1;
    shift = 1'b1; tick(); exp_wr("s1", 16'h0003, 8'h0B, 1'b0);
    tick(); exp_idle("gap");
    shift = 1'b1; tick(); exp_wr("s2", 16'h0004, 8'h0C, 1'b0);
    shift = 1'b1; tick(); exp_wr("s3", 16'h0005, 8'h0D, 1'b1);
    shift = 1'b1; tick(); exp_idle("empty shift");
    chk("empty busy", 32'(busy), 32'd0);

    // addr_init coincident with a shift
    load = 1'b1; par_in = 32'h000000C1; tick();
    addr_init = 1'b1; base_addr = 16'h0300; shift = 1'b1; tick();
    exp_wr("ai0", 16'h0300, 8'hC1, 1'b0);
    shift = 1'b1; tick(); exp_wr("ai1", 16'h0301, 8'h00, 1'b0);
    clr = 1'b1; tick();

    // load+shift with empty register, then reset mid-transfer
    load = 1'b1; shift = 1'b1; par_in = 32'h24232221; tick();
    exp_idle("ldsh");
    chk("ldsh busy", 32'(busy), 32'd1);
    shift = 1'b1; tick(); exp_wr("r0", 16'h0302, 8'h21, 1'b0);
    shift = 1'b1; tick(); exp_wr("r1", 16'h0303, 8'h22, 1'b0);
    reset = 1'b1; shift = 1'b1; tick();
    chk("mrst wr_addr", 32'(wr_addr), 32'd0);
    chk("mrst wr_data", 32'(wr_data), 32'd0);
    chk("mrst busy", 32'(busy), 32'd0);
    exp_idle("mrst");
    reset = 1'b0;
    shift = 1'b1; tick(); exp_idle("post rst shift");
    shift = 1'b1; tick(); exp_idle("post rst shift2");
    load = 1'b1; par_in = 32'h000000EE; tick();
    shift = 1'b1; tick(); exp_wr("post rst wr", 16'h0000, 8'hEE, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_out_writer.md
PISO_OUT_WRITER -- requirements
Module: piso_out_writer

Interface
REQ-001 Parameter LANES, default 4, number of parallel result lanes loaded per transfer.
REQ-002 Parameter DW, default 8, bits per lane (post-ReLU result width).
REQ-003 Parameter AW, default 16, output memory address width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  global stall; low freezes all state.
REQ-007 clr  input  1  clear shift register and lane count.
REQ-008 load  input  1  parallel load strobe from the accumulate/ReLU stage.
REQ-009 par_in  input  LANES*DW  ReLU results; lane k at bits [k*DW +: DW].
REQ-010 shift  input  1  request to emit one lane to memory.
REQ-011 addr_init  input  1  latch base_addr into the write-address counter.
REQ-012 base_addr  input  AW  start address for output writes.
REQ-013 wr_en  output  1  registered memory write strobe.
REQ-014 wr_addr  output  AW  registered write address, valid when wr_en=1.
REQ-015 wr_data  output  DW  registered write data, valid when wr_en=1.
REQ-016 out_done  output  1  one-cycle pulse on the cycle the final lane's write is presented.
REQ-017 busy  output  1  high while lane count is non-zero.
REQ-018 overrun  output  1  sticky flag: load arrived while busy.

Function
REQ-019 All state updates SHALL occur only when enable=1; when enable=0, all registers SHALL hold, with wr_en and out_done additionally forced to 0 on the next edge.
REQ-020 Internal state SHALL comprise the shift register (LANES*DW), lane count cnt (0..LANES), and write-address counter addr (AW).
REQ-021 Priority per enabled cycle SHALL be: clr > load > shift.
REQ-022 clr: shift register := 0; cnt := 0; overrun := 0; wr_en and out_done := 0 that cycle; addr unchanged.
REQ-023 load with cnt=0: shift register := par_in; cnt := LANES; any simultaneous shift ignored; wr_en := 0.
REQ-024 load with cnt!=0: load ignored, overrun := 1, and a simultaneous shift is processed normally.
REQ-025 shift with cnt>0: wr_data := lane 0; wr_addr := addr; wr_en := 1; register shifts right by DW with zero fill; cnt := cnt-1; addr := addr+1.
REQ-026 shift with cnt=0: no write; wr_en := 0; no state change.
REQ-027 out_done SHALL be 1 exactly on the cycle wr_en=1 carries the write that took cnt from 1 to 0; otherwise 0.
REQ-028 Latency: the write for a shift accepted at edge N SHALL be visible on wr_* after edge N; back-to-back shifts SHALL yield one write per cycle.
REQ-029 addr SHALL wrap modulo 2^AW (all-ones + 1 = 0) without flagging.
REQ-030 addr_init SHALL load addr := base_addr; if coincident with an accepted shift, that write SHALL use base_addr and addr := base_addr+1.
REQ-031 busy SHALL equal (cnt!=0), driven from registered state.
REQ-032 wr_en SHALL be 0 on any cycle without an accepted shift.

Reset
REQ-033 On reset=1 (regardless of enable): shift register, cnt, addr, wr_en, wr_addr, wr_data, out_done, busy, overrun SHALL all be 0.
REQ-034 Reset mid-transfer SHALL abandon remaining lanes with no further writes and no out_done pulse.

Verification
REQ-035 Reset, addr_init base=0x0100, load par_in=0x44332211, 4 shifts -> writes (0x0100,0x11),(0x0101,0x22),(0x0102,0x33),(0x0103,0x44); out_done only with 0x44; busy low after.
REQ-036 Load while cnt=2 -> overrun=1, remaining lanes unchanged; clr -> overrun=0, busy=0, addr unchanged.
REQ-037 base=0xFFFE, load, 4 shifts -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-038 Shift pulses with enable=0 between them -> no writes during stall, writes resume in order; shift with cnt=0 -> wr_en stays 0.
REQ-039 Load+shift same cycle with cnt=0 -> load only, no write; reset after 2 of 4 writes -> all outputs 0, no out_done.
